// File: rtl/scic_mem_arbiter.sv
// scic_mem_arbiter: shares the SCIC single-port program/data memory
// between the CPU core and the program loader.
//
// Each accepted request runs IDLE -> ACCESS -> RESP -> IDLE. The
// address, write data and write flag are latched when the request is
// accepted. The memory returns read data in RESP. The owner's ack
// pulses in RESP.
//
// Parameters : ADDR_W (word address width), DATA_W (word width)
// Clock/reset: clock, reset (synchronous, active high)
// CPU port   : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_ack, cpu_rdata
// Loader port: ldr_req, ldr_we, ldr_addr, ldr_wdata -> ldr_ack, ldr_rdata
// Memory     : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
// Status     : busy (high in ACCESS and RESP)
//
// Build option: define SCIC_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking. Without it, the CPU always wins a tie.

module scic_mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_ack,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t            state;
   logic              own_ldr;
   logic              lat_we;
   logic [DATA_W-1:0] cpu_hold;
   logic [DATA_W-1:0] ldr_hold;
   logic              grant_ldr;

`ifdef SCIC_ARB_ROUND_ROBIN_EN
   // 1 = loader was served most recently
   logic              last_ldr;

   // A lone requester wins. A tie goes to the side not served last.
   always_comb begin
      grant_ldr = ldr_req && (!cpu_req || !last_ldr);
   end
`else
   // Fixed priority: the loader wins only when the CPU is quiet.
   always_comb begin
      grant_ldr = ldr_req && !cpu_req;
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         own_ldr   <= 1'b0;
         lat_we    <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_ack   <= 1'b0;
         ldr_ack   <= 1'b0;
         busy      <= 1'b0;
         cpu_hold  <= '0;
         ldr_hold  <= '0;
`ifdef SCIC_ARB_ROUND_ROBIN_EN
         last_ldr  <= 1'b1;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (cpu_req || ldr_req) begin
                  // The mem_* registers double as the request latch.
                  own_ldr   <= grant_ldr;
                  lat_we    <= grant_ldr ? ldr_we : cpu_we;
                  mem_en    <= 1'b1;
                  mem_we    <= grant_ldr ? ldr_we : cpu_we;
                  mem_addr  <= grant_ldr ? ldr_addr : cpu_addr;
                  mem_wdata <= grant_ldr ? ldr_wdata : cpu_wdata;
                  busy      <= 1'b1;
                  state     <= ACCESS;
`ifdef SCIC_ARB_ROUND_ROBIN_EN
                  last_ldr  <= grant_ldr;
`endif
               end
            end
            ACCESS: begin
               mem_en  <= 1'b0;
               mem_we  <= 1'b0;
               cpu_ack <= !own_ldr;
               ldr_ack <= own_ldr;
               state   <= RESP;
            end
            RESP: begin
               cpu_ack <= 1'b0;
               ldr_ack <= 1'b0;
               busy    <= 1'b0;
               if (!lat_we) begin
                  if (own_ldr) begin
                     ldr_hold <= mem_rdata;
                  end else begin
                     cpu_hold <= mem_rdata;
                  end
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Read data goes straight through during the owner's read ack.
   // Otherwise the last captured read is shown.
   assign cpu_rdata = (cpu_ack && !lat_we) ? mem_rdata : cpu_hold;
   assign ldr_rdata = (ldr_ack && !lat_we) ? mem_rdata : ldr_hold;

endmodule

// File: tb/tb_scic_mem_arbiter.sv
// tb_scic_mem_arbiter: randomized self-checking bench for
// scic_mem_arbiter, with a transaction-level reference model.

module tb_scic_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic        ldr_req = 1'b0;
   logic        ldr_we = 1'b0;
   logic [15:0] ldr_addr = '0;
   logic [31:0] ldr_wdata = '0;
   logic        ldr_ack;
   logic [31:0] ldr_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        busy;

   int n_checks = 0;
   int n_fail = 0;

   scic_mem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ldr_req(ldr_req), .ldr_we(ldr_we),
      .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
      .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clock = ~clock;

   // Memory macro stand-in: synchronous, read-before-write.
   bit [31:0] mem [0:65535];
   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         mem_rdata <= mem[mem_addr];
      end
   end

   // Reference model: memory contents, per-requester read hold,
   // and who was served last.
   bit [31:0]   ref_mem [0:65535];
   logic [31:0] ref_cpu_hold = '0;
   logic [31:0] ref_ldr_hold = '0;
   bit          ref_last_ldr = 1'b1;

   function automatic bit pick_ldr(input bit c, input bit l);
      bit rr = 1'b0;
`ifdef SCIC_ARB_ROUND_ROBIN_EN
      rr = 1'b1;
`endif
      if (!l) return 1'b0;
      if (!c) return 1'b1;
      return rr && !ref_last_ldr;
   endfunction

   task automatic serve(input bit is_ldr, input bit we,
                        input logic [15:0] a, input logic [31:0] d,
                        output logic [31:0] exp);
      ref_last_ldr = is_ldr;
      if (we) begin
         ref_mem[a] = d;
         exp = is_ldr ? ref_ldr_hold : ref_cpu_hold;
      end else begin
         exp = ref_mem[a];
         if (is_ldr) ref_ldr_hold = exp;
         else ref_cpu_hold = exp;
      end
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset = 1'b1;
      cpu_req = 1'b0;
      ldr_req = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      ref_cpu_hold = '0;
      ref_ldr_hold = '0;
      ref_last_ldr = 1'b1;
   endtask

   // Observations collected by run_slot
   int          c_acks, l_acks, c_ack_n, l_ack_n;
   logic [31:0] c_ack_data, l_ack_data;
   logic        n1_en, n1_we;
   logic [15:0] n1_addr;

   // Raise the selected requests together, drop each on its ack,
   // watch for 12 cycles.
   task automatic run_slot(
      input bit c_on, input bit c_w,
      input logic [15:0] c_a, input logic [31:0] c_d,
      input bit l_on, input bit l_w,
      input logic [15:0] l_a, input logic [31:0] l_d);
      @(negedge clock);
      cpu_req = c_on; cpu_we = c_w;
      cpu_addr = c_a; cpu_wdata = c_d;
      ldr_req = l_on; ldr_we = l_w;
      ldr_addr = l_a; ldr_wdata = l_d;
      c_acks = 0; l_acks = 0;
      c_ack_n = 0; l_ack_n = 0;
      c_ack_data = '0; l_ack_data = '0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clock);
         if (n == 1) begin
            n1_en = mem_en;
            n1_we = mem_we;
            n1_addr = mem_addr;
         end
         if (cpu_ack) begin
            c_acks++;
            if (c_ack_n == 0) begin
               c_ack_n = n;
               c_ack_data = cpu_rdata;
            end
            cpu_req = 1'b0;
         end
         if (ldr_ack) begin
            l_acks++;
            if (l_ack_n == 0) begin
               l_ack_n = n;
               l_ack_data = ldr_rdata;
            end
            ldr_req = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] e;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      n_checks++;
      if ({mem_en, mem_we, cpu_ack, ldr_ack, busy} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 00000",
                  {mem_en, mem_we, cpu_ack, ldr_ack, busy});
      end
      n_checks++;
      if ({mem_addr, mem_wdata} !== 48'h0) begin
         n_fail++;
         $display("FAIL reset_mem_bus: got %h/%h want 0/0",
                  mem_addr, mem_wdata);
      end
      n_checks++;
      if ({cpu_rdata, ldr_rdata} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h/%h want 0/0",
                  cpu_rdata, ldr_rdata);
      end
      reset = 1'b0;
      e = '0;
      if (e !== '0) $display("unreachable");
   endtask

   task automatic test_cpu_read();
      logic [31:0] e;
      run_slot(0, 0, 0, 0, 1, 1, 16'h0010, 32'hDEADBEEF);
      serve(1, 1, 16'h0010, 32'hDEADBEEF, e);
      apply_reset();
      run_slot(1, 0, 16'h0010, 0, 0, 0, 0, 0);
      serve(0, 0, 16'h0010, 0, e);
      n_checks++;
      if ({n1_en, n1_we, n1_addr} !== {1'b1, 1'b0, 16'h0010}) begin
         n_fail++;
         $display("FAIL cpu_read_access: en/we/addr %b/%b/%h want 1/0/0010",
                  n1_en, n1_we, n1_addr);
      end
      n_checks++;
      if (c_acks !== 1 || c_ack_n !== 2) begin
         n_fail++;
         $display("FAIL cpu_read_ack: %0d acks at cycle %0d want 1 at 2",
                  c_acks, c_ack_n);
      end
      n_checks++;
      if (c_ack_data !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL cpu_read_data: got %h want deadbeef", c_ack_data);
      end
      n_checks++;
      if (cpu_rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL cpu_read_hold: got %h want deadbeef", cpu_rdata);
      end
   endtask

   task automatic test_ldr_write_cpu_read();
      logic [31:0] e;
      run_slot(0, 0, 0, 0, 1, 1, 16'h0004, 32'h12345678);
      serve(1, 1, 16'h0004, 32'h12345678, e);
      n_checks++;
      if (l_acks !== 1 || c_acks !== 0) begin
         n_fail++;
         $display("FAIL ldr_write_ack: ldr %0d cpu %0d want 1/0",
                  l_acks, c_acks);
      end
      run_slot(1, 0, 16'h0004, 0, 0, 0, 0, 0);
      serve(0, 0, 16'h0004, 0, e);
      n_checks++;
      if (c_ack_data !== 32'h12345678 || cpu_rdata !== 32'h12345678) begin
         n_fail++;
         $display("FAIL cpu_read_back: ack %h hold %h want 12345678",
                  c_ack_data, cpu_rdata);
      end
      n_checks++;
      if (ldr_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL ldr_rdata_kept: got %h want 0", ldr_rdata);
      end
   endtask

   task automatic test_tie();
      bit   exp_order [4];
      bit   got_order [4];
      int   got = 0;
      logic [31:0] e;
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         exp_order[k] = pick_ldr(1, 1);
         if (exp_order[k]) serve(1, 0, 16'h0004, 0, e);
         else serve(0, 0, 16'h0010, 0, e);
      end
      @(negedge clock);
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
      ldr_req = 1; ldr_we = 0; ldr_addr = 16'h0004;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clock);
         if (got < 4 && cpu_ack) begin
            got_order[got] = 1'b0;
            got++;
         end
         if (got < 4 && ldr_ack) begin
            got_order[got] = 1'b1;
            got++;
         end
         if (n == 12) begin
            cpu_req = 0;
            ldr_req = 0;
         end
      end
      repeat (3) @(negedge clock);
      n_checks++;
      if (got !== 4) begin
         n_fail++;
         $display("FAIL tie_count: got %0d acks want 4", got);
      end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (k < got && got_order[k] !== exp_order[k]) begin
            n_fail++;
            $display("FAIL tie_order[%0d]: got ldr=%b want ldr=%b",
                     k, got_order[k], exp_order[k]);
         end
      end
      n_checks++;
      if (cpu_rdata !== ref_cpu_hold || ldr_rdata !== ref_ldr_hold) begin
         n_fail++;
         $display("FAIL tie_rdata: got %h/%h want %h/%h",
                  cpu_rdata, ldr_rdata, ref_cpu_hold, ref_ldr_hold);
      end
   endtask

   task automatic test_addr_change();
      logic [31:0] e;
      logic [31:0] v20, v30;
      int          ack_n = 0;
      logic [31:0] ack_d = '0;
      logic [15:0] a1 = '0;
      v20 = $urandom;
      v30 = ~v20;
      run_slot(1, 1, 16'h0020, v20, 0, 0, 0, 0);
      serve(0, 1, 16'h0020, v20, e);
      run_slot(0, 0, 0, 0, 1, 1, 16'h0030, v30);
      serve(1, 1, 16'h0030, v30, e);
      serve(0, 0, 16'h0020, 0, e);
      @(negedge clock);
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clock);
         if (n == 1) begin
            a1 = mem_addr;
            cpu_addr = 16'h0030;
         end
         if (cpu_ack && ack_n == 0) begin
            ack_n = n;
            ack_d = cpu_rdata;
            cpu_req = 0;
         end
      end
      n_checks++;
      if (a1 !== 16'h0020) begin
         n_fail++;
         $display("FAIL addr_latch: mem_addr %h want 0020", a1);
      end
      n_checks++;
      if (ack_n !== 2 || ack_d !== e) begin
         n_fail++;
         $display("FAIL addr_latch_data: cycle %0d data %h want 2/%h",
                  ack_n, ack_d, e);
      end
   endtask

   task automatic test_reset_in_access();
      logic [31:0] e;
      int          ack_n = 0;
      logic [31:0] ack_d = '0;
      @(negedge clock);
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
      @(negedge clock);
      n_checks++;
      if (mem_en !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_access_en: mem_en %b want 1", mem_en);
      end
      reset = 1'b1;
      @(negedge clock);
      n_checks++;
      if ({mem_en, busy, cpu_ack, ldr_ack} !== 4'b0) begin
         n_fail++;
         $display("FAIL rst_access_abort: en/busy/acks %b want 0000",
                  {mem_en, busy, cpu_ack, ldr_ack});
      end
      reset = 1'b0;
      ref_cpu_hold = '0;
      ref_ldr_hold = '0;
      ref_last_ldr = 1'b1;
      serve(0, 0, 16'h0010, 0, e);
      for (int n = 1; n <= 5; n++) begin
         @(negedge clock);
         if (cpu_ack && ack_n == 0) begin
            ack_n = n;
            ack_d = cpu_rdata;
            cpu_req = 0;
         end
      end
      n_checks++;
      if (ack_n !== 2 || ack_d !== e) begin
         n_fail++;
         $display("FAIL rst_reissue: cycle %0d data %h want 2/%h",
                  ack_n, ack_d, e);
      end
   endtask

   task automatic test_idle();
      cpu_req = 0;
      ldr_req = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clock);
         n_checks++;
         if ({mem_en, busy, cpu_ack, ldr_ack} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle[%0d]: en/busy/acks %b want 0000",
                     n, {mem_en, busy, cpu_ack, ldr_ack});
         end
      end
   endtask

   task automatic test_random();
      bit          c_on, l_on, c_w, l_w, fl;
      logic [15:0] c_a, l_a;
      logic [31:0] c_d, l_d, ce, le;
      int          cn, ln;
      for (int s = 0; s < 40; s++) begin
         c_on = 1'($urandom);
         l_on = 1'($urandom);
         if (!c_on && !l_on) c_on = 1'b1;
         c_w = 1'($urandom);
         l_w = 1'($urandom);
         c_a = 16'h0040 + 16'($urandom_range(0, 7));
         l_a = 16'h0040 + 16'($urandom_range(0, 7));
         c_d = $urandom;
         l_d = $urandom;
         run_slot(c_on, c_w, c_a, c_d, l_on, l_w, l_a, l_d);
         cn = 0; ln = 0; ce = '0; le = '0;
         if (c_on && l_on) begin
            fl = pick_ldr(1, 1);
            if (fl) begin
               serve(1, l_w, l_a, l_d, le);
               serve(0, c_w, c_a, c_d, ce);
               ln = 2; cn = 5;
            end else begin
               serve(0, c_w, c_a, c_d, ce);
               serve(1, l_w, l_a, l_d, le);
               cn = 2; ln = 5;
            end
         end else if (c_on) begin
            serve(0, c_w, c_a, c_d, ce);
            cn = 2;
         end else begin
            serve(1, l_w, l_a, l_d, le);
            ln = 2;
         end
         n_checks++;
         if (c_acks !== (c_on ? 1 : 0) || c_ack_n !== cn) begin
            n_fail++;
            $display("FAIL rnd%0d_cpu_ack: %0d acks at %0d want %0d at %0d",
                     s, c_acks, c_ack_n, c_on ? 1 : 0, cn);
         end
         n_checks++;
         if (l_acks !== (l_on ? 1 : 0) || l_ack_n !== ln) begin
            n_fail++;
            $display("FAIL rnd%0d_ldr_ack: %0d acks at %0d want %0d at %0d",
                     s, l_acks, l_ack_n, l_on ? 1 : 0, ln);
         end
         n_checks++;
         if (c_ack_data !== ce || l_ack_data !== le) begin
            n_fail++;
            $display("FAIL rnd%0d_ack_data: got %h/%h want %h/%h",
                     s, c_ack_data, l_ack_data, ce, le);
         end
         n_checks++;
         if (cpu_rdata !== ref_cpu_hold || ldr_rdata !== ref_ldr_hold) begin
            n_fail++;
            $display("FAIL rnd%0d_hold: got %h/%h want %h/%h",
                     s, cpu_rdata, ldr_rdata, ref_cpu_hold, ref_ldr_hold);
         end
      end
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_ldr_write_cpu_read();
      test_tie();
      test_addr_change();
      test_reset_in_access();
      test_idle();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
